// File: rtl/sound_scheduler_if.sv
// Handshake bundle between the alarm requesters and the tone scheduler.
// The slave side is the scheduler; the master side drives the requests.
interface sound_scheduler_if;
  logic [3:0] req;
  logic       tone_en;
  logic [1:0] tone_sel;
  logic       busy;
  logic [3:0] done;

  modport master (output req, input tone_en, tone_sel, busy, done);
  modport slave  (input req, output tone_en, tone_sel, busy, done);
endinterface

// File: rtl/sound_scheduler.sv
// Fixed-priority arbiter and beep sequencer for the shared tone output:
// grants one requester, plays BEEPS on/off bursts, then holds a guard gap.
module sound_scheduler #(
  parameter int TICK_DIV  = 50000,
  parameter int ON_TICKS  = 200,
  parameter int OFF_TICKS = 100,
  parameter int GAP_TICKS = 500,
  parameter int BEEPS     = 3
) (
  input  logic              clk,
  input  logic              reset,
  sound_scheduler_if.slave  bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ON   = 2'd1;
  localparam logic [1:0] OFF  = 2'd2;
  localparam logic [1:0] GAP  = 2'd3;

  localparam int PRESC_W   = $clog2(TICK_DIV);
  localparam int MAX_TICKS = (ON_TICKS > OFF_TICKS)
                             ? ((ON_TICKS > GAP_TICKS) ? ON_TICKS : GAP_TICKS)
                             : ((OFF_TICKS > GAP_TICKS) ? OFF_TICKS : GAP_TICKS);
  // The phase counter is 8 bits unless a tick count needs more headroom.
  localparam int PHASE_W   = ($clog2(MAX_TICKS) > 8) ? $clog2(MAX_TICKS) : 8;

  logic [1:0]         state, state_d;
  logic [PRESC_W-1:0] presc;
  logic [PHASE_W-1:0] phase;
  logic [3:0]         beep, beep_d;
  logic [1:0]         grant, grant_d;
  logic [3:0]         done_d;
  logic               tick;

  function automatic logic [1:0] lowest_set(input logic [3:0] r);
    lowest_set = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (r[i]) lowest_set = 2'(i);
    end
  endfunction

  assign tick = (presc == PRESC_W'(TICK_DIV - 1));

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d = state;
    beep_d  = beep;
    grant_d = grant;
    done_d  = '0;
    case (state)
      IDLE: begin
        if (|bus.req) begin
          state_d = ON;
          grant_d = lowest_set(bus.req);
          beep_d  = 4'd1;
        end
      end
      ON: begin
        if (!bus.req[grant]) begin
          state_d = GAP;
          beep_d  = '0;
        end else if (tick && phase == PHASE_W'(ON_TICKS - 1)) begin
          if (beep == 4'(BEEPS)) begin
            state_d        = GAP;
            beep_d         = '0;
            done_d[grant]  = 1'b1;
          end else begin
            state_d = OFF;
          end
        end
      end
      OFF: begin
        if (!bus.req[grant]) begin
          state_d = GAP;
          beep_d  = '0;
        end else if (tick && phase == PHASE_W'(OFF_TICKS - 1)) begin
          state_d = ON;
          beep_d  = beep + 4'd1;
        end
      end
      default: begin
        if (tick && phase == PHASE_W'(GAP_TICKS - 1)) state_d = IDLE;
      end
    endcase
  end

  // Outputs are registered from the next-state decode so they line up with the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      presc       <= '0;
      phase       <= '0;
      beep        <= '0;
      grant       <= '0;
      bus.tone_en <= 1'b0;
      bus.busy    <= 1'b0;
      bus.done    <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state       <= state_d;
      beep        <= beep_d;
      grant       <= grant_d;
      bus.tone_en <= (state_d == ON);
      bus.busy    <= (state_d != IDLE);
      bus.done    <= done_d;
      if (state_d != state || state == IDLE) begin
        presc <= '0;
        phase <= '0;
      end else if (tick) begin
        presc <= '0;
        phase <= phase + PHASE_W'(1);
      end else begin
        presc <= presc + PRESC_W'(1);
      end
    end
  end

  assign bus.tone_sel = grant;

endmodule

// File: tb/tb_sound_scheduler.sv
// Directed bench for sound_scheduler: per-cycle expectation tables plus
// hand-written reset sequences, using small tick counts.
module tb_sound_scheduler;

  logic clk;
  logic reset;
  sound_scheduler_if bus ();

  sound_scheduler #(
    .TICK_DIV (4),
    .ON_TICKS (2),
    .OFF_TICKS(1),
    .GAP_TICKS(3),
    .BEEPS    (2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic       en;
    logic [1:0] sel;
    logic       busy;
    logic [3:0] done;
  } vec_t;

  vec_t vecs[$];
  int   n_pass;
  int   n_total;

  function automatic logic [7:0] obs();
    return {bus.tone_en, bus.tone_sel, bus.busy, bus.done};
  endfunction

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got {en,sel,busy,done}=%b expected %b", name, got, exp);
  endtask

  task automatic add(input int n, input logic [3:0] r, input logic en,
                     input logic [1:0] sel, input logic b, input logic [3:0] d);
    vec_t v;
    v.req = r; v.en = en; v.sel = sel; v.busy = b; v.done = d;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  // One undisturbed sequence: 8 on, 4 off, 8 on, 12 gap (done on the first), one idle.
  task automatic add_full_seq(input logic [3:0] r, input logic [1:0] sel);
    add(8,  r,     1'b1, sel, 1'b1, 4'b0000);
    add(4,  r,     1'b0, sel, 1'b1, 4'b0000);
    add(8,  r,     1'b1, sel, 1'b1, 4'b0000);
    add(1,  r,     1'b0, sel, 1'b1, r);
    add(11, 4'b0,  1'b0, sel, 1'b1, 4'b0000);
    add(1,  4'b0,  1'b0, sel, 1'b0, 4'b0000);
  endtask

  // Entry k drives req before edge k and expects the outputs seen after it.
  task automatic run_table(input string tag);
    foreach (vecs[i]) begin
      bus.req = vecs[i].req;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("%s[%0d]", tag, i), obs(),
            {vecs[i].en, vecs[i].sel, vecs[i].busy, vecs[i].done});
    end
    vecs.delete();
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    clk     = 1'b0;
    reset   = 1'b1;
    bus.req = 4'b0000;

    #1 reset = 1'b0;
    #1 check("reset_init", obs(), 8'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("reset_hold%0d", i), obs(), 8'b0);
    end
    reset = 1'b1;

    // Idle with no requests, then a single requester 2.
    add(5, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b0000);
    add_full_seq(4'b0100, 2'd2);
    add(1, 4'b0000, 1'b0, 2'd2, 1'b0, 4'b0000);

    // Simultaneous 1 and 3: requester 1 wins, 3 follows after one idle cycle.
    add(8,  4'b1010, 1'b1, 2'd1, 1'b1, 4'b0000);
    add(4,  4'b1010, 1'b0, 2'd1, 1'b1, 4'b0000);
    add(8,  4'b1010, 1'b1, 2'd1, 1'b1, 4'b0000);
    add(1,  4'b1010, 1'b0, 2'd1, 1'b1, 4'b0010);
    add(11, 4'b1000, 1'b0, 2'd1, 1'b1, 4'b0000);
    add(1,  4'b1000, 1'b0, 2'd1, 1'b0, 4'b0000);

    // Requester 3 runs; req[0] rises mid first ON without preempting it.
    add(4,  4'b1000, 1'b1, 2'd3, 1'b1, 4'b0000);
    add(4,  4'b1001, 1'b1, 2'd3, 1'b1, 4'b0000);
    add(4,  4'b1001, 1'b0, 2'd3, 1'b1, 4'b0000);
    add(8,  4'b1001, 1'b1, 2'd3, 1'b1, 4'b0000);
    add(1,  4'b1001, 1'b0, 2'd3, 1'b1, 4'b1000);
    add(11, 4'b1001, 1'b0, 2'd3, 1'b1, 4'b0000);
    add(1,  4'b1001, 1'b0, 2'd3, 1'b0, 4'b0000);
    // Requester 0 granted, then aborted in its first ON cycle.
    add(1,  4'b1001, 1'b1, 2'd0, 1'b1, 4'b0000);
    add(12, 4'b0000, 1'b0, 2'd0, 1'b1, 4'b0000);
    add(1,  4'b0000, 1'b0, 2'd0, 1'b0, 4'b0000);

    // Requester 1 dropped on cycle 10 (OFF): 12-cycle gap, no done.
    add(8,  4'b0010, 1'b1, 2'd1, 1'b1, 4'b0000);
    add(2,  4'b0010, 1'b0, 2'd1, 1'b1, 4'b0000);
    add(12, 4'b0000, 1'b0, 2'd1, 1'b1, 4'b0000);
    add(2,  4'b0000, 1'b0, 2'd1, 1'b0, 4'b0000);

    @(negedge clk);
    run_table("seq");

    // Reset asserted mid-cycle during the second ON of requester 2.
    add(8, 4'b0100, 1'b1, 2'd2, 1'b1, 4'b0000);
    add(4, 4'b0100, 1'b0, 2'd2, 1'b1, 4'b0000);
    add(2, 4'b0100, 1'b1, 2'd2, 1'b1, 4'b0000);
    run_table("pre_rst");
    #2 reset = 1'b0;
    #1 check("rst_async", obs(), 8'b0);
    @(posedge clk);
    @(negedge clk);
    check("rst_held", obs(), 8'b0);
    reset = 1'b1;
    add_full_seq(4'b0100, 2'd2);
    run_table("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
